// File: rtl/sext_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sext_rr_arbiter_if
// Description : Bundles the two byte requesters, the 32-bit result channel
//               and the transfer counter of sext_rr_arbiter.
//               slave  - arbiter side: takes requests and out_ready, drives
//                        the readies, the result and xfer_count.
//               master - environment side: the mirror image of slave.
// Ports       : none (clk and reset travel as plain ports on the arbiter).
// Revision    : 1.0 - initial release
// ============================================================================
interface sext_rr_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready;
    logic [15:0] xfer_count;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src, xfer_count
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src, xfer_count
    );
endinterface
`default_nettype wire

// File: rtl/sext_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sext_rr_arbiter
// Description : Two-requester round-robin arbiter feeding one shared byte
//               extender (sign or zero, chosen per requester by ZERO_EXT)
//               and a single-entry output register. The output register
//               can drain and refill in the same cycle, so a continuously
//               ready consumer sees one result per cycle.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous, active-high reset
//               bus    - sext_rr_arbiter_if.slave (requests, readies,
//                        result channel, xfer_count)
// Revision    : 1.0 - initial release
// ============================================================================
module sext_rr_arbiter #(
    parameter logic [1:0] ZERO_EXT = 2'b00
) (
    input  wire logic          clk,
    input  wire logic          reset,
    sext_rr_arbiter_if.slave   bus
);

    localparam logic c_ST_EMPTY = 1'b0;
    localparam logic c_ST_FULL  = 1'b1;

    logic        r_state;
    logic        r_ptr;      // requester favoured on the next contention
    logic [31:0] r_data;
    logic        r_src;
    logic [15:0] r_count;

    logic        w_can_accept;
    logic        w_grant;
    logic        w_accept;
    logic        w_take;
    logic [7:0]  w_sel_data;
    logic [31:0] w_ext_data;

    // A full register may be refilled in the very cycle it is drained.
    assign w_can_accept = (r_state == c_ST_EMPTY) || bus.out_ready;

    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = r_ptr;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Reset gates acceptance so no requester sees a ready while in reset.
    assign w_accept = !reset && w_can_accept && (bus.req0_valid || bus.req1_valid);
    assign w_take   = (r_state == c_ST_FULL) && bus.out_ready;

    assign w_sel_data = w_grant ? bus.req1_data : bus.req0_data;
    assign w_ext_data = ZERO_EXT[w_grant] ? {24'h000000, w_sel_data}
                                          : {{24{w_sel_data[7]}}, w_sel_data};

    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept &&  w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
            r_ptr   <= 1'b0;
            r_data  <= 32'h0000_0000;
            r_src   <= 1'b0;
            r_count <= 16'h0000;
        end else begin
            if (w_take) begin
                r_count <= r_count + 16'd1;
            end
            if (w_accept) begin
                r_data <= w_ext_data;
                r_src  <= w_grant;
                r_ptr  <= ~w_grant;
            end
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= c_ST_FULL;
                    end
                end
                c_ST_FULL: begin
                    if (bus.out_ready && !w_accept) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                default: r_state <= c_ST_EMPTY;
            endcase
        end
    end

    assign bus.out_valid  = (r_state == c_ST_FULL);
    assign bus.out_data   = r_data;
    assign bus.out_src    = r_src;
    assign bus.xfer_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sext_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sext_rr_arbiter
// Description : Self-checking bench for sext_rr_arbiter. The stimulus task
//               runs a small reference model; accepted transfers push their
//               expected result into a queue that an independent monitor
//               pops whenever the arbiter presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sext_rr_arbiter;

    localparam logic [1:0] c_ZE = 2'b10;  // req0 sign-extends, req1 zero-extends

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sext_rr_arbiter_if u_if ();

    sext_rr_arbiter #(.ZERO_EXT(c_ZE)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected results: {src, data}
    logic [32:0] exp_q[$];

    // Reference model state
    logic        m_full;
    logic        m_ptr;
    logic [15:0] m_count;

    function automatic logic [31:0] ext(input logic [7:0] d, input logic src);
        logic [1:0] ze;
        ze = c_ZE;
        return ze[src] ? {24'h000000, d} : {{24{d[7]}}, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: mid-cycle, compare the presented result with the queue head.
    always @(negedge clk) begin
        if (!reset && u_if.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h src %0d, expected none", u_if.out_data, u_if.out_src);
            end else begin
                chk("out_data", u_if.out_data, exp_q[0][31:0]);
                chk("out_src", {31'd0, u_if.out_src}, {31'd0, exp_q[0][32]});
                if (u_if.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; drives one cycle of inputs and returns at the
    // next posedge+1.
    task automatic step(input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic ordy);
        logic can, g, acc;
        u_if.req0_valid = v0;
        u_if.req0_data  = d0;
        u_if.req1_valid = v1;
        u_if.req1_data  = d1;
        u_if.out_ready  = ordy;
        #1;
        can = !m_full || ordy;
        g   = (v0 && v1) ? m_ptr : v1;
        acc = can && (v0 || v1);
        chk("req0_ready", {31'd0, u_if.req0_ready}, {31'd0, acc && !g});
        chk("req1_ready", {31'd0, u_if.req1_ready}, {31'd0, acc && g});
        chk("out_valid", {31'd0, u_if.out_valid}, {31'd0, m_full});
        chk("xfer_count", {16'd0, u_if.xfer_count}, {16'd0, m_count});
        if (m_full && ordy) m_count = m_count + 16'd1;
        if (acc) begin
            exp_q.push_back({g, ext(g ? d1 : d0, g)});
            m_ptr  = ~g;
            m_full = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with reset already released.
    task automatic do_reset();
        reset           = 1'b1;
        u_if.req0_valid = 1'b1;
        u_if.req1_valid = 1'b1;
        u_if.out_ready  = 1'b0;
        #1;
        chk("rst_req0_ready", {31'd0, u_if.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, u_if.req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        chk("rst_out_data", u_if.out_data, 32'h0);
        chk("rst_out_src", {31'd0, u_if.out_src}, 32'd0);
        chk("rst_xfer_count", {16'd0, u_if.xfer_count}, 32'd0);
        reset           = 1'b0;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        exp_q.delete();
        m_full  = 1'b0;
        m_ptr   = 1'b0;
        m_count = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        u_if.req0_valid = 1'b0;
        u_if.req0_data  = 8'h00;
        u_if.req1_valid = 1'b0;
        u_if.req1_data  = 8'h00;
        u_if.out_ready  = 1'b0;
        m_full  = 1'b0;
        m_ptr   = 1'b0;
        m_count = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single sign-extended byte, accepted in the first cycle out of reset
        step(1'b1, 8'h85, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);   // out_ready while empty: ignored

        // Zero-extend on req1, positive byte on req0
        step(1'b0, 8'h00, 1'b1, 8'h85, 1'b1);
        step(1'b1, 8'h7F, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Contention from reset: grants 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h01 + 8'(i), 1'b1, 8'hF0 + 8'(i), 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Backpressure: hold FFFFFF80 for 5 cycles, then drain + refill
        do_reset();
        step(1'b1, 8'h80, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h81, 1'b1, 8'h02, 1'b0);
        end
        step(1'b1, 8'h81, 1'b1, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Valid dropped without handshake while full
        step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Reset while full discards the result; pointer back to req0
        step(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Counter wrap after 65536 takes
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 8'(i), 1'b1, 8'(~i), 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("wrap_xfer_count", {16'd0, u_if.xfer_count}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
